demux_tdm_rx: RTL

Frame-synchronised time-division demultiplexer: the receive end of the 4-to-1 selector datapath. An upstream selector serialises NR_CH channel values, slot 0 first, onto one DATA_LEN-bit lane. This block counts slots, steers each beat into its channel register and publishes the reassembled parallel word with a one-cycle strobe. It sits between the serial lane and the NVBoard-facing LED/segment logic.

---
 rtl/demux_tdm_rx.sv | 82 ++++++++
 1 files changed

// File: rtl/demux_tdm_rx.sv
// rtl/demux_tdm_rx.sv - frame-synchronised TDM receive demultiplexer
module demux_tdm_rx #(
    parameter int NR_CH    = 4,
    parameter int DATA_LEN = 1,
    parameter int SLOT_LEN = $clog2(NR_CH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic                      in_sof,
    input  logic [DATA_LEN-1:0]       in_data,
    output logic [NR_CH*DATA_LEN-1:0] out_data,
    output logic                      out_valid,
    output logic [SLOT_LEN-1:0]       out_slot,
    output logic                      err
);

    localparam int W = NR_CH * DATA_LEN;
    localparam logic [SLOT_LEN-1:0] LAST_SLOT = SLOT_LEN'(NR_CH - 1);

    typedef enum logic {IDLE, RECV} state_t;

    state_t              state;
    logic [SLOT_LEN-1:0] slot;
    logic [W-1:0]        shadow;
    logic [W-1:0]        merged;

    // Shadow with the current beat dropped into the current slot; used both
    // for accumulation and so the final beat reaches out_data on commit.
    always_comb begin
        merged = shadow;
        merged[int'(slot)*DATA_LEN +: DATA_LEN] = in_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            slot      <= '0;
            shadow    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            err       <= 1'b0;
            if (in_valid) begin
                case (state)
                    IDLE: begin
                        if (in_sof) begin
                            shadow[DATA_LEN-1:0] <= in_data;
                            slot                 <= SLOT_LEN'(1);
                            state                <= RECV;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    RECV: begin
                        if (in_sof) begin
                            // Restart: the open frame is abandoned, this beat is slot 0.
                            err                  <= 1'b1;
                            shadow[DATA_LEN-1:0] <= in_data;
                            slot                 <= SLOT_LEN'(1);
                        end else if (slot == LAST_SLOT) begin
                            shadow    <= merged;
                            out_data  <= merged;
                            out_valid <= 1'b1;
                            slot      <= '0;
                            state     <= IDLE;
                        end else begin
                            shadow <= merged;
                            slot   <= slot + SLOT_LEN'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign out_slot = slot;

endmodule
